fcache_arb: RTL and testbench
=============================

FCACHE_ARB -- requirements
Module: fcache_arb

Interface
REQ-001 The module SHALL have parameter WORD_W, default 16, requester word width in bits.
REQ-002 The module SHALL have parameter LINE_W, default 256, fcache line width in bits; LINE_W/WORD_W = 16 words per line.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port r0_req, input, 1 bit, fetch-port request.
REQ-006 The module SHALL have port r0_we, input, 1 bit, fetch-port write enable (1 = write, 0 = read).
REQ-007 The module SHALL have port r0_addr, input, 16 bits, fetch-port word address.
REQ-008 The module SHALL have port r0_wdata, input, WORD_W bits, fetch-port write word.
REQ-009 The module SHALL have port r0_ack, output, 1 bit, fetch-port one-cycle completion pulse.
REQ-010 The module SHALL have port r0_rdata, output, WORD_W bits, fetch-port read word, valid while r0_ack=1 and held afterwards.
REQ-011 The module SHALL have ports r1_req, r1_we, r1_addr, r1_wdata, r1_ack and r1_rdata, identical to the r0_* ports, for the data port.
REQ-012 The module SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-013 The module SHALL have port c_write, output, 1 bit, fcache write strobe.
REQ-014 The module SHALL have port c_addr, output, 16 bits, fcache line address.
REQ-015 The module SHALL have port c_wData, output, LINE_W bits, fcache write line.
REQ-016 The module SHALL have port c_rData, input, LINE_W bits, fcache read line; it is combinational from c_addr, and the fcache writes on the rising clk edge when c_write=1.

Function
REQ-017 Address split SHALL be: line index = addr[15:4], word select k = addr[3:0], and c_addr = {4'b0, line index}.
REQ-018 Word k SHALL occupy line bits [16k+15:16k].
REQ-019 The FSM SHALL have states IDLE, LOOKUP, WRITE and DONE.
REQ-020 IDLE SHALL behave as follows:
- If no request is present, the FSM stays in IDLE.
- Otherwise the arbiter grants one requester; its we, addr and wdata are latched; next state is LOOKUP.
REQ-021 Arbitration SHALL be round-robin:
- A lone request is granted.
- If both requests are present, the requester not granted last wins.
- The last-grant register resets to 1, so r0 wins the first conflict.
REQ-022 LOOKUP SHALL behave as follows:
- c_addr is driven from the latched address.
- On a read, word k of c_rData is captured into the granted rdata register; next state is DONE.
- On a write, c_rData with word k replaced by the latched wdata is captured into the line register; next state is WRITE.
REQ-023 In WRITE, c_write SHALL be 1 and c_wData SHALL equal the line register for exactly one cycle; next state is DONE.
REQ-024 In DONE, the granted ack SHALL be 1 for exactly one cycle, the last-grant register SHALL update, and the next state SHALL be IDLE.
REQ-025 Latency SHALL be: read ack high 2 cycles after the edge that samples req; write ack high 3 cycles after it.
REQ-026 c_write SHALL be 0 in every state except WRITE, and the non-granted ack SHALL never assert.
REQ-027 Requests SHALL be sampled only in IDLE:
- A requester deasserts req in the cycle after ack.
- A req still high in IDLE is a new transaction.
- Dropping req after grant does not cancel the transaction.
REQ-028 Requester inputs SHALL be ignored after latching; changes to addr, we or wdata mid-transaction have no effect.
REQ-029 The rdata registers SHALL change only on a read LOOKUP for that requester; writes leave them unchanged.

Reset
REQ-030 On rst_n=0 the module SHALL, immediately and independent of clk:
- set the FSM to IDLE;
- set c_write=0, busy=0, r0_ack=0 and r1_ack=0;
- clear r0_rdata, r1_rdata, c_addr, c_wData and the latches to 0;
- set the last-grant register to 1.
REQ-031 Reset asserted in WRITE SHALL drop c_write before the next edge, so no fcache write occurs; the aborted transaction is never acked.
REQ-032 After rst_n rises, the first rising edge SHALL sample requests in IDLE.

Structure
REQ-033 Package fcache_pkg SHALL hold the state enum, WORD_W, LINE_W, WORDS_PER_LINE=16 and ADDR_W=16.
REQ-034 Round-robin grant logic SHALL be the sub-module fcache_rr_arb (inputs req[1:0] and last; output grant index); word select/merge stays inline.

Verification
REQ-035 The bench SHALL cover a lone read: fcache line 0x012 preloaded with word 5 = 16'hBEEF; r0 reads 16'h0125 -> r0_ack is high 2 cycles after sampling, r0_rdata = BEEF, c_write never asserts.
REQ-036 The bench SHALL cover a write merge: r1 writes 16'hA5A5 to 16'h0037 over a line of all 1s -> one c_write pulse, c_addr = 16'h0003, c_wData = all 1s except bits [127:112] = A5A5, r1_ack 3 cycles after sampling.
REQ-037 The bench SHALL cover a conflict: r0 and r1 request in the same cycle, both held across 4 transactions -> grant order r0, r1, r0, r1, with one ack each.
REQ-038 The bench SHALL cover a read-after-write: r0 writes 16'h1234 to 16'hFFFF, then r1 reads 16'hFFFF -> r1_rdata = 1234, and the other 15 words of line 16'h0FFF are unchanged.
REQ-039 The bench SHALL cover reset mid-write: rst_n=0 during WRITE -> c_write drops within the same cycle, the line is unchanged, no ack, and after release a new read of the same address returns the old word.
REQ-040 The bench SHALL cover a held request: r0_req held high continuously -> a new transaction every 3 cycles (read), and busy=0 for exactly one cycle between transactions.

Source files
------------

// File: rtl/fcache_pkg.sv
// fcache_pkg: shared geometry and FSM state type for the fcache arbiter
package fcache_pkg;
  localparam int WORD_W = 16;
  localparam int LINE_W = 256;
  localparam int WORDS_PER_LINE = 16;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, DONE} state_e;
endpackage

// File: rtl/fcache_rr_arb.sv
// fcache_rr_arb: two-way round-robin grant index
// Ports: req_i[1:0] requests, last_i index granted last, grant_o index to grant
module fcache_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);
  // On a conflict the requester not granted last wins; a lone request wins outright.
  assign grant_o = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/fcache_arb.sv
// fcache_arb: arbitrates a fetch port (r0) and data port (r1) onto a line-wide fcache
// Ports: r0_*/r1_* word requesters (req/we/addr/wdata in, ack pulse/rdata out),
//        busy (FSM not idle), c_write/c_addr/c_wData/c_rData fcache line interface
module fcache_arb #(
  parameter int WORD_W = 16,
  parameter int LINE_W = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         r0_req,
  input  logic                         r0_we,
  input  logic [fcache_pkg::ADDR_W-1:0] r0_addr,
  input  logic [WORD_W-1:0]            r0_wdata,
  output logic                         r0_ack,
  output logic [WORD_W-1:0]            r0_rdata,
  input  logic                         r1_req,
  input  logic                         r1_we,
  input  logic [fcache_pkg::ADDR_W-1:0] r1_addr,
  input  logic [WORD_W-1:0]            r1_wdata,
  output logic                         r1_ack,
  output logic [WORD_W-1:0]            r1_rdata,
  output logic                         busy,
  output logic                         c_write,
  output logic [fcache_pkg::ADDR_W-1:0] c_addr,
  output logic [LINE_W-1:0]            c_wData,
  input  logic [LINE_W-1:0]            c_rData
);
  import fcache_pkg::*;
  localparam int KW = $clog2(WORDS_PER_LINE);
  state_e state_q;
  logic gnt, gnt_q, last_q, we_q, c_write_q;
  logic [1:0] ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q, rdata0_q, rdata1_q, word_d;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] rline, line_d, line_q;
  fcache_rr_arb u_arb (.req_i({r1_req, r0_req}), .last_i(last_q), .grant_o(gnt));
  // Word-indexed view of the line so word k sits at bits [16k+15:16k].
  assign rline = c_rData;
  assign word_d = rline[addr_q[KW-1:0]];
  always_comb begin
    line_d = rline;
    line_d[addr_q[KW-1:0]] = wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      line_q    <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      c_write_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      c_write_q <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        IDLE: if (r0_req || r1_req) begin
          state_q <= LOOKUP;
          gnt_q   <= gnt;
          we_q    <= gnt ? r1_we : r0_we;
          addr_q  <= gnt ? r1_addr : r0_addr;
          wdata_q <= gnt ? r1_wdata : r0_wdata;
        end
        LOOKUP: if (we_q) begin
          line_q    <= line_d;
          c_write_q <= 1'b1;
          state_q   <= WRITE;
        end else begin
          if (gnt_q) rdata1_q <= word_d;
          else rdata0_q <= word_d;
          ack_q   <= {gnt_q, ~gnt_q};
          state_q <= DONE;
        end
        WRITE: begin
          ack_q   <= {gnt_q, ~gnt_q};
          state_q <= DONE;
        end
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = state_q != IDLE;
  assign c_write  = c_write_q;
  assign c_addr   = {{KW{1'b0}}, addr_q[ADDR_W-1:KW]};
  assign c_wData  = line_q;
  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;
endmodule

// File: tb/tb_fcache_arb.sv
// tb_fcache_arb: scoreboard bench for fcache_arb against a word-addressed memory model
module tb_fcache_arb;
  logic clk, rst_n;
  logic r0_req, r0_we, r1_req, r1_we;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata, r0_rdata, r1_rdata;
  logic r0_ack, r1_ack, busy, c_write;
  logic [15:0] c_addr;
  logic [255:0] c_wData, c_rData;

  fcache_arb dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .busy(busy), .c_write(c_write), .c_addr(c_addr), .c_wData(c_wData), .c_rData(c_rData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fcache storage (line view) and reference model (word view)
  logic [255:0] mem [4096];
  logic [15:0] ref_words [65536];
  assign c_rData = mem[c_addr[11:0]];
  always @(posedge clk) if (c_write) mem[c_addr[11:0]] = c_wData;

  typedef struct { bit port; int cyc; logic [15:0] rdata; } exp_t;
  typedef struct { logic [15:0] addr; logic [255:0] line; int cyc; } wr_t;
  exp_t exp_q [$];
  wr_t wr_q [$];
  int n_cmp = 0, n_fail = 0, n_cwrite = 0;
  int cyc = 0, free_m = 0, busy_last = -1, pend_cyc = -1;
  bit last_m = 1'b1, g_m, we_m;
  logic [15:0] a_m, d_m, pend_a, pend_d;
  logic [15:0] rd_m [2] = '{16'h0, 16'h0};
  logic [255:0] l_m;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  function automatic logic [255:0] line_of(input int idx);
    logic [255:0] l;
    for (int w = 0; w < 16; w++) l[w*16 +: 16] = ref_words[idx*16 + w];
    return l;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    ref_words[a] = d;
    mem[a[15:4]][int'(a[3:0])*16 +: 16] = d;
  endtask

  task automatic set_port(input bit p, input bit rq, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (p) begin r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d; end
    else begin r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d; end
  endtask

  // One transaction on an idle arbiter; inputs are scrambled once granted.
  task automatic txn(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    set_port(p, 1'b1, we, a, d);
    @(negedge clk);
    set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    n = 0;
    while (!(p ? r1_ack : r0_ack) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail("txn_ack_timeout");
    set_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Transaction-level model: a grant happens on any edge where the arbiter is free
  // and a request is present; reads finish in 3 cycles, writes in 4.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      wr_q.delete();
      last_m = 1'b1;
      free_m = 0;
      busy_last = -1;
      pend_cyc = -1;
      rd_m[0] = 16'h0;
      rd_m[1] = 16'h0;
    end else begin
      cyc++;
      if (cyc == pend_cyc) ref_words[pend_a] = pend_d;
      if (cyc >= free_m && (r0_req || r1_req)) begin
        g_m = (r0_req && r1_req) ? !last_m : r1_req;
        we_m = g_m ? r1_we : r0_we;
        a_m = g_m ? r1_addr : r0_addr;
        d_m = g_m ? r1_wdata : r0_wdata;
        if (we_m) begin
          l_m = line_of(int'(a_m[15:4]));
          l_m[int'(a_m[3:0])*16 +: 16] = d_m;
          wr_q.push_back('{{4'b0, a_m[15:4]}, l_m, cyc + 1});
          exp_q.push_back('{g_m, cyc + 2, rd_m[g_m]});
          pend_a = a_m;
          pend_d = d_m;
          pend_cyc = cyc + 2;
          free_m = cyc + 4;
          busy_last = cyc + 2;
        end else begin
          rd_m[g_m] = ref_words[a_m];
          exp_q.push_back('{g_m, cyc + 1, rd_m[g_m]});
          free_m = cyc + 3;
          busy_last = cyc + 1;
        end
        last_m = g_m;
      end
    end
  end

  // Monitor: compares every presented ack / write strobe with the scoreboard.
  initial forever begin
    exp_t e;
    wr_t w;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_acks", {r1_ack, r0_ack}, 2'b00);
      chk("rst_cwrite", c_write, 1'b0);
    end else begin
      chk("busy", busy, cyc <= busy_last);
      chk("ack_onehot", r0_ack & r1_ack, 1'b0);
      if (r0_ack || r1_ack) begin
        if (exp_q.size() == 0) fail("ack_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("ack_port", r1_ack, e.port);
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_rdata", e.port ? r1_rdata : r0_rdata, e.rdata);
        end
      end
      if (c_write) begin
        n_cwrite++;
        if (wr_q.size() == 0) fail("cwrite_unexpected");
        else begin
          w = wr_q.pop_front();
          chk("cwrite_addr", c_addr, w.addr);
          chk("cwrite_line", c_wData, w.line);
          chk("cwrite_cycle", cyc, w.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, cw;
    int log_q [$];
    logic [255:0] pre, expl;
    bit pend [2];
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 65536; i++) ref_words[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) mem[i] = line_of(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_c_write", c_write, 1'b0);
    chk("rst_r0_rdata", r0_rdata, 16'h0);
    chk("rst_r1_rdata", r1_rdata, 16'h0);
    chk("rst_c_addr", c_addr, 16'h0);
    chk("rst_c_wData", c_wData, 256'h0);
    chk("rst_ack", {r1_ack, r0_ack}, 2'b00);
    rst_n = 1'b1;

    // Lone read of a preloaded word
    poke(16'h0125, 16'hBEEF);
    cw = n_cwrite;
    txn(0, 1'b0, 16'h0125, 16'h0);
    chk("read_r0_rdata", r0_rdata, 16'hBEEF);
    chk("read_no_cwrite", n_cwrite, cw);

    // Write merge into a line of all ones
    for (int w = 0; w < 16; w++) poke(16'h0030 + 16'(w), 16'hFFFF);
    cw = n_cwrite;
    txn(1, 1'b1, 16'h0037, 16'hA5A5);
    expl = '1;
    expl[127:112] = 16'hA5A5;
    chk("merge_one_cwrite", n_cwrite, cw + 1);
    chk("merge_line", mem[3], expl);

    // Conflict with both requests held for four transactions
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'($urandom), 16'h0);
    set_port(1, 1'b1, 1'b0, 16'($urandom), 16'h0);
    n = 0;
    while (log_q.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (r0_ack) log_q.push_back(0);
      if (r1_ack) log_q.push_back(1);
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    if (log_q.size() < 4) fail("conflict_timeout");
    else for (int i = 0; i < 4; i++) chk("conflict_order", log_q[i], i % 2);

    // Read after write at the top address
    pre = mem[12'hFFF];
    txn(0, 1'b1, 16'hFFFF, 16'h1234);
    txn(1, 1'b0, 16'hFFFF, 16'h0);
    chk("raw_r1_rdata", r1_rdata, 16'h1234);
    expl = pre;
    expl[255:240] = 16'h1234;
    chk("raw_line", mem[12'hFFF], expl);

    // Reset during WRITE
    pre = mem[12'h012];
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 16'h0125, 16'h5A5A);
    @(posedge clk);
    @(negedge clk);
    r0_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_cwrite_before", c_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstw_cwrite_drop", c_write, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("rstw_line_kept", mem[12'h012], pre);
    rst_n = 1'b1;
    txn(0, 1'b0, 16'h0125, 16'h0);
    chk("rstw_old_word", r0_rdata, 16'hBEEF);

    // Held read request
    log_q.delete();
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 16'($urandom), 16'h0);
    n = 0;
    while (log_q.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (r0_ack) log_q.push_back(cyc);
      r0_addr = 16'($urandom);
    end
    r0_req = 1'b0;
    if (log_q.size() < 5) fail("held_timeout");
    else for (int i = 1; i < 5; i++) chk("held_period", log_q[i] - log_q[i-1], 3);

    // Randomised traffic on a small address window
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if ((p == 1) ? r1_ack : r0_ack) begin
          pend[p] = $urandom_range(0, 9) < 3;
          set_port(1'(p), pend[p], 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom));
        end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          set_port(1'(p), 1'b1, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom));
        end else if (pend[p] && $urandom_range(0, 4) == 0)
          set_port(1'(p), 1'b1, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom));
      end
    end
    set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_acks", exp_q.size(), 0);
    chk("drain_writes", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
